// File: rtl/token_ring_scheduler.sv
// Rotating-priority scheduler granting one exclusive resource to N requesters,
// with a READY stage before each grant and a hold-time watchdog that revokes.
module token_ring_scheduler #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 15,
  parameter int OW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [OW-1:0] owner,
  output logic          busy,
  output logic [N-1:0]  revoke
);

  typedef enum logic [1:0] {IDLE, READY, BUSY} state_t;

  localparam logic [7:0]    HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [OW-1:0] LAST_IDX  = OW'(N - 1);

  state_t        state_reg, state_next;
  logic [OW-1:0] ptr_reg, ptr_next;
  logic [OW-1:0] owner_reg, owner_next;
  logic [OW-1:0] owner_inc;
  logic [OW-1:0] sel_idx;
  logic          sel_found;
  logic [7:0]    hold_cnt_reg, hold_cnt_next;
  logic [N-1:0]  mask_reg, mask_next;
  logic [N-1:0]  grant_reg, grant_next;
  logic [N-1:0]  revoke_reg, revoke_next;
  logic          busy_reg, busy_next;
  logic [N-1:0]  ereq;
  logic [OW-1:0] cand [N];

  assign ereq      = req & ~mask_reg;
  assign owner_inc = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;

  // cand[k] is (ptr + k) mod N, the k-th position in the rotating scan order.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [OW:0] sum;
      assign sum = {1'b0, ptr_reg} + (OW+1)'(gi);
      assign cand[gi] = (sum >= (OW+1)'(N)) ? OW'(sum - (OW+1)'(N)) : sum[OW-1:0];
    end
  endgenerate

  // Scan from the far end so the position closest to ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (ereq[cand[k]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      hold_cnt_reg <= '0;
      mask_reg     <= '0;
      grant_reg    <= '0;
      revoke_reg   <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      hold_cnt_reg <= hold_cnt_next;
      mask_reg     <= mask_next;
      grant_reg    <= grant_next;
      revoke_reg   <= revoke_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sel_found) state_next = READY;
      READY:   state_next = BUSY;
      BUSY:    if (!req[owner_reg] || hold_cnt_reg == HOLD_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Release is tested before timeout, so a simultaneous drop never revokes.
  always_comb begin
    grant_next    = '0;
    revoke_next   = '0;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    hold_cnt_next = hold_cnt_reg;
    mask_next     = mask_reg & req;
    case (state_reg)
      IDLE: begin
        if (sel_found) owner_next = sel_idx;
      end
      READY: begin
        grant_next[owner_reg] = 1'b1;
        hold_cnt_next         = '0;
      end
      BUSY: begin
        if (!req[owner_reg]) begin
          ptr_next = owner_inc;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          revoke_next[owner_reg] = 1'b1;
          mask_next[owner_reg]   = 1'b1;
          ptr_next               = owner_inc;
        end else begin
          grant_next[owner_reg] = 1'b1;
          hold_cnt_next         = hold_cnt_reg + 8'd1;
        end
      end
      default: ;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign grant  = grant_reg;
  assign revoke = revoke_reg;
  assign owner  = owner_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_token_ring_scheduler.sv
// Table-driven bench: each row drives inputs for one edge; the expected outputs
// are queued at drive time and compared one cycle later.
module tb_token_ring_scheduler;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] grant;
    logic [2:0] revoke;
    logic       busy;
    int         owner;
    int         ptr;
    logic [2:0] mask;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic [2:0] revoke;

  logic       rst_wd = 1'b1;
  logic [2:0] req_wd = 3'b000;
  logic [2:0] grant_wd;
  logic [1:0] owner_wd;
  logic       busy_wd;
  logic [2:0] revoke_wd;

  int checks   = 0;
  int failures = 0;

  vec_t main_tab[$];
  vec_t wd_tab[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  token_ring_scheduler #(.N(3), .MAX_HOLD(15)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .owner(owner), .busy(busy), .revoke(revoke)
  );

  token_ring_scheduler #(.N(3), .MAX_HOLD(4)) dut_wd (
    .clk(clk), .rst(rst_wd), .req(req_wd), .grant(grant_wd),
    .owner(owner_wd), .busy(busy_wd), .revoke(revoke_wd)
  );

  task automatic check(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic add(input bit wd, input logic r, input logic [2:0] rq, input logic [2:0] g,
                     input logic [2:0] rv, input logic b, input int o, input int p,
                     input logic [2:0] m, input int count);
    vec_t v;
    v.rst = r; v.req = rq; v.grant = g; v.revoke = rv;
    v.busy = b; v.owner = o; v.ptr = p; v.mask = m;
    for (int i = 0; i < count; i++) begin
      if (wd) wd_tab.push_back(v);
      else    main_tab.push_back(v);
    end
  endtask

  task automatic step(input bit wd, input vec_t v, input int row);
    vec_t e;
    logic [2:0] g, rv, m;
    logic b;
    int o, p;
    string tag;
    if (wd) begin rst_wd = v.rst; req_wd = v.req; end
    else    begin rst    = v.rst; req    = v.req; end
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (wd) begin
      g = grant_wd; rv = revoke_wd; b = busy_wd; o = int'(owner_wd);
      p = int'(dut_wd.ptr_reg); m = dut_wd.mask_reg; tag = "wd";
    end else begin
      g = grant; rv = revoke; b = busy; o = int'(owner);
      p = int'(dut.ptr_reg); m = dut.mask_reg; tag = "main";
    end
    check({tag, "_grant"},   row, int'(g),  int'(e.grant));
    check({tag, "_revoke"},  row, int'(rv), int'(e.revoke));
    check({tag, "_busy"},    row, int'(b),  int'(e.busy));
    check({tag, "_owner"},   row, o,        e.owner);
    check({tag, "_ptr"},     row, p,        e.ptr);
    check({tag, "_mask"},    row, int'(m),  int'(e.mask));
    check({tag, "_onehot0"}, row, int'($onehot0(g)), 1);
    check({tag, "_rev_grant_overlap"}, row, int'(g & rv), 0);
    $display("%s row %0d rst=%b req=%b grant=%b revoke=%b busy=%b owner=%0d ptr=%0d",
             tag, row, e.rst, e.req, g, rv, b, o, p);
  endtask

  initial begin
    // Main instance (MAX_HOLD=15): reset, round-robin, reset mid-BUSY,
    // single requester, ptr wrap, reset mid-BUSY again.
    //      wd rst req     grant   revoke  busy o  p  mask    count
    add(0, 1, 3'b111, 3'b000, 3'b000, 0, 0, 0, 3'b000, 3);
    add(0, 0, 3'b111, 3'b000, 3'b000, 1, 0, 0, 3'b000, 1);
    add(0, 0, 3'b111, 3'b001, 3'b000, 1, 0, 0, 3'b000, 3);
    add(0, 0, 3'b110, 3'b000, 3'b000, 0, 0, 1, 3'b000, 1);
    add(0, 0, 3'b111, 3'b000, 3'b000, 1, 1, 1, 3'b000, 1);
    add(0, 0, 3'b111, 3'b010, 3'b000, 1, 1, 1, 3'b000, 3);
    add(0, 0, 3'b101, 3'b000, 3'b000, 0, 1, 2, 3'b000, 1);
    add(0, 0, 3'b111, 3'b000, 3'b000, 1, 2, 2, 3'b000, 1);
    add(0, 0, 3'b111, 3'b100, 3'b000, 1, 2, 2, 3'b000, 3);
    add(0, 0, 3'b011, 3'b000, 3'b000, 0, 2, 0, 3'b000, 1);
    add(0, 0, 3'b111, 3'b000, 3'b000, 1, 0, 0, 3'b000, 1);
    add(0, 0, 3'b111, 3'b001, 3'b000, 1, 0, 0, 3'b000, 1);
    add(0, 1, 3'b111, 3'b000, 3'b000, 0, 0, 0, 3'b000, 1);
    add(0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b000, 1);
    add(0, 0, 3'b010, 3'b000, 3'b000, 1, 1, 0, 3'b000, 1);
    add(0, 0, 3'b010, 3'b010, 3'b000, 1, 1, 0, 3'b000, 5);
    add(0, 0, 3'b000, 3'b000, 3'b000, 0, 1, 2, 3'b000, 1);
    add(0, 0, 3'b100, 3'b000, 3'b000, 1, 2, 2, 3'b000, 1);
    add(0, 0, 3'b100, 3'b100, 3'b000, 1, 2, 2, 3'b000, 1);
    add(0, 0, 3'b001, 3'b000, 3'b000, 0, 2, 0, 3'b000, 1);
    add(0, 0, 3'b101, 3'b000, 3'b000, 1, 0, 0, 3'b000, 1);
    add(0, 0, 3'b101, 3'b001, 3'b000, 1, 0, 0, 3'b000, 1);
    add(0, 1, 3'b101, 3'b000, 3'b000, 0, 0, 0, 3'b000, 1);
    add(0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b000, 1);

    // Watchdog instance (MAX_HOLD=4): timeout and revoke, masked re-request,
    // then release landing exactly on the timeout cycle.
    add(1, 1, 3'b000, 3'b000, 3'b000, 0, 0, 0, 3'b000, 1);
    add(1, 0, 3'b001, 3'b000, 3'b000, 1, 0, 0, 3'b000, 1);
    add(1, 0, 3'b001, 3'b001, 3'b000, 1, 0, 0, 3'b000, 4);
    add(1, 0, 3'b001, 3'b000, 3'b001, 0, 0, 1, 3'b001, 1);
    add(1, 0, 3'b001, 3'b000, 3'b000, 0, 0, 1, 3'b001, 2);
    add(1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 3'b000, 1);
    add(1, 0, 3'b001, 3'b000, 3'b000, 1, 0, 1, 3'b000, 1);
    add(1, 0, 3'b001, 3'b001, 3'b000, 1, 0, 1, 3'b000, 4);
    add(1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 3'b000, 1);
    add(1, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 3'b000, 1);

    for (int i = 0; i < main_tab.size(); i++) step(1'b0, main_tab[i], i);
    for (int i = 0; i < wd_tab.size(); i++)   step(1'b1, wd_tab[i], i);

    check("scoreboard_drained", 0, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
